// File: rtl/cory_merge8_if.sv
// Eight upstream valid/ready streams plus one downstream stream
// for the round-robin merge.
interface cory_merge8_if #(
    parameter int N = 16
);
    logic         i_a0_v, i_a1_v, i_a2_v, i_a3_v;
    logic         i_a4_v, i_a5_v, i_a6_v, i_a7_v;
    logic [N-1:0] i_a0_d, i_a1_d, i_a2_d, i_a3_d;
    logic [N-1:0] i_a4_d, i_a5_d, i_a6_d, i_a7_d;
    logic         o_a0_r, o_a1_r, o_a2_r, o_a3_r;
    logic         o_a4_r, o_a5_r, o_a6_r, o_a7_r;
    logic         o_z_v;
    logic [N-1:0] o_z_d;
    logic [2:0]   o_z_s;
    logic         i_z_r;

    modport slave (
        input  i_a0_v, i_a1_v, i_a2_v, i_a3_v,
        input  i_a4_v, i_a5_v, i_a6_v, i_a7_v,
        input  i_a0_d, i_a1_d, i_a2_d, i_a3_d,
        input  i_a4_d, i_a5_d, i_a6_d, i_a7_d,
        output o_a0_r, o_a1_r, o_a2_r, o_a3_r,
        output o_a4_r, o_a5_r, o_a6_r, o_a7_r,
        output o_z_v, o_z_d, o_z_s,
        input  i_z_r
    );

    modport master (
        output i_a0_v, i_a1_v, i_a2_v, i_a3_v,
        output i_a4_v, i_a5_v, i_a6_v, i_a7_v,
        output i_a0_d, i_a1_d, i_a2_d, i_a3_d,
        output i_a4_d, i_a5_d, i_a6_d, i_a7_d,
        input  o_a0_r, o_a1_r, o_a2_r, o_a3_r,
        input  o_a4_r, o_a5_r, o_a6_r, o_a7_r,
        input  o_z_v, o_z_d, o_z_s,
        output i_z_r
    );
endinterface

// File: rtl/cory_merge8.sv
// Eight-to-one stream merge with a registered, source-tagged output
// and rotating (or fixed) priority arbitration.
module cory_merge8 #(
    parameter int N  = 16,
    parameter bit RR = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    cory_merge8_if.slave   bus
);
    logic [7:0]   req;
    logic [N-1:0] din [8];
    logic [7:0]   rdy;
    logic         load;
    logic         found;
    logic [2:0]   g;

    logic         z_v_q, z_v_d;
    logic [N-1:0] z_d_q, z_d_d;
    logic [2:0]   z_s_q, z_s_d;
    logic [2:0]   ptr_q, ptr_d;

    assign req = {bus.i_a7_v, bus.i_a6_v, bus.i_a5_v, bus.i_a4_v,
                  bus.i_a3_v, bus.i_a2_v, bus.i_a1_v, bus.i_a0_v};

    assign din[0] = bus.i_a0_d;
    assign din[1] = bus.i_a1_d;
    assign din[2] = bus.i_a2_d;
    assign din[3] = bus.i_a3_d;
    assign din[4] = bus.i_a4_d;
    assign din[5] = bus.i_a5_d;
    assign din[6] = bus.i_a6_d;
    assign din[7] = bus.i_a7_d;

    assign load = !z_v_q | bus.i_z_r;

    // First requester at or after ptr, wrapping modulo 8.
    always_comb begin
        found = 1'b0;
        g     = ptr_q;
        for (int i = 0; i < 8; i++) begin
            if (!found && req[ptr_q + 3'(i)]) begin
                found = 1'b1;
                g     = ptr_q + 3'(i);
            end
        end
    end

    assign rdy = (load && found && !reset) ? (8'd1 << g) : 8'd0;

    assign bus.o_a0_r = rdy[0];
    assign bus.o_a1_r = rdy[1];
    assign bus.o_a2_r = rdy[2];
    assign bus.o_a3_r = rdy[3];
    assign bus.o_a4_r = rdy[4];
    assign bus.o_a5_r = rdy[5];
    assign bus.o_a6_r = rdy[6];
    assign bus.o_a7_r = rdy[7];

    always_comb begin
        z_v_d = z_v_q;
        z_d_d = z_d_q;
        z_s_d = z_s_q;
        ptr_d = ptr_q;
        if (load) begin
            if (found) begin
                z_v_d = 1'b1;
                z_d_d = din[g];
                z_s_d = g;
                ptr_d = RR ? g + 3'd1 : 3'd0;
            end else begin
                z_v_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            z_v_q <= 1'b0;
            z_d_q <= '0;
            z_s_q <= 3'd0;
            ptr_q <= 3'd0;
        end else begin
            z_v_q <= z_v_d;
            z_d_q <= z_d_d;
            z_s_q <= z_s_d;
            ptr_q <= ptr_d;
        end
    end

    assign bus.o_z_v = z_v_q;
    assign bus.o_z_d = z_d_q;
    assign bus.o_z_s = z_s_q;
endmodule

// File: tb/tb_cory_merge8.sv
// Directed and random checks of cory_merge8 against a queue-based
// reference model; a second instance covers fixed priority.
module tb_cory_merge8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        zr  = 1'b1;
    logic        tv [8];
    logic [15:0] td [8];
    logic [15:0] src [8][$];
    wire  [7:0]  rv;

    int n_chk = 0;
    int n_fail = 0;
    int pushed = 0;
    int delivered = 0;
    int dropped = 0;

    bit          m_v = 1'b0;
    logic [15:0] m_d = '0;
    int          m_s = 0;
    int          m_ptr = 0;

    cory_merge8_if #(.N(16)) bus1 ();
    cory_merge8_if #(.N(16)) bus0 ();

    cory_merge8 #(.N(16), .RR(1'b1)) u_rr (
        .clk(clk), .reset(rst), .bus(bus1)
    );
    cory_merge8 #(.N(16), .RR(1'b0)) u_fp (
        .clk(clk), .reset(rst), .bus(bus0)
    );

    always #5 clk = ~clk;

    assign bus1.i_a0_v = tv[0];
    assign bus1.i_a1_v = tv[1];
    assign bus1.i_a2_v = tv[2];
    assign bus1.i_a3_v = tv[3];
    assign bus1.i_a4_v = tv[4];
    assign bus1.i_a5_v = tv[5];
    assign bus1.i_a6_v = tv[6];
    assign bus1.i_a7_v = tv[7];
    assign bus1.i_a0_d = td[0];
    assign bus1.i_a1_d = td[1];
    assign bus1.i_a2_d = td[2];
    assign bus1.i_a3_d = td[3];
    assign bus1.i_a4_d = td[4];
    assign bus1.i_a5_d = td[5];
    assign bus1.i_a6_d = td[6];
    assign bus1.i_a7_d = td[7];
    assign bus1.i_z_r  = zr;
    assign rv = {bus1.o_a7_r, bus1.o_a6_r, bus1.o_a5_r, bus1.o_a4_r,
                 bus1.o_a3_r, bus1.o_a2_r, bus1.o_a1_r, bus1.o_a0_r};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] r, input int p);
        for (int i = 0; i < 8; i++) begin
            if (r[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    task automatic push(input int k, input logic [15:0] d);
        src[k].push_back(d);
        pushed++;
    endtask

    // One clock: present queue heads, check against model, advance.
    task automatic cyc(input bit chk_out);
        logic [7:0] req;
        logic [7:0] er;
        logic [7:0] hs;
        bit         ld;
        int         g;
        for (int k = 0; k < 8; k++) begin
            tv[k] = (src[k].size() != 0);
            td[k] = (src[k].size() != 0) ? src[k][0] : 16'h0;
            req[k] = tv[k];
        end
        #1;
        ld = !m_v || zr;
        g  = (ld && !rst) ? pick(req, m_ptr) : -1;
        er = (g >= 0) ? (8'd1 << g) : 8'd0;
        chk("ready", {24'd0, rv}, {24'd0, er});
        if (chk_out) begin
            chk("z_v", {31'd0, bus1.o_z_v}, {31'd0, m_v});
            chk("z_d", {16'd0, bus1.o_z_d}, {16'd0, m_d});
            chk("z_s", {29'd0, bus1.o_z_s}, 32'(m_s));
        end
        hs = rv & req;
        @(posedge clk);
        if (m_v && zr) delivered++;
        if (rst) begin
            if (m_v && !zr) dropped++;
            m_v = 0; m_d = '0; m_s = 0; m_ptr = 0;
        end else if (ld) begin
            if (g >= 0) begin
                m_v = 1; m_d = td[g]; m_s = g; m_ptr = (g + 1) % 8;
            end else begin
                m_v = 0;
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (hs[k] && src[k].size() != 0) void'(src[k].pop_front());
        end
        #1;
    endtask

    function automatic bit busy();
        for (int k = 0; k < 8; k++) if (src[k].size() != 0) return 1;
        return m_v;
    endfunction

    task automatic drain();
        int guard = 0;
        zr = 1'b1;
        while (busy() && guard < 200) begin
            cyc(1);
            guard++;
        end
        chk("drain_done", {31'd0, busy()}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 8; k++) begin
            tv[k] = 1'b0;
            td[k] = '0;
        end
        {bus0.i_a0_v, bus0.i_a1_v, bus0.i_a2_v, bus0.i_a3_v} = '0;
        {bus0.i_a4_v, bus0.i_a5_v, bus0.i_a6_v, bus0.i_a7_v} = '0;
        {bus0.i_a0_d, bus0.i_a1_d, bus0.i_a2_d, bus0.i_a3_d} = '0;
        {bus0.i_a4_d, bus0.i_a5_d, bus0.i_a6_d, bus0.i_a7_d} = '0;
        bus0.i_z_r = 1'b1;

        // Reset with every input valid: nothing granted.
        for (int k = 0; k < 8; k++) begin
            push(k, 16'(k << 4));
            push(k, 16'(k << 4));
        end
        rst = 1'b1;
        cyc(0);
        for (int i = 0; i < 3; i++) cyc(1);

        // Full rotation from ptr 0 with no bubbles.
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("rot_v", {31'd0, bus1.o_z_v}, 32'd1);
            chk("rot_s", {29'd0, bus1.o_z_s}, 32'(i % 8));
        end
        drain();

        // Pointer skip: after granting 2, inputs 1 and 6 compete.
        push(2, 16'h2222);
        cyc(1);
        push(1, 16'h1111);
        push(6, 16'h6666);
        push(6, 16'h6667);
        cyc(1);
        chk("skip_a", {29'd0, bus1.o_z_s}, 32'd6);
        cyc(1);
        chk("skip_b", {29'd0, bus1.o_z_s}, 32'd1);
        cyc(1);
        chk("skip_c", {29'd0, bus1.o_z_s}, 32'd6);
        drain();

        // Backpressure holding BEEF from input 5.
        push(5, 16'hBEEF);
        cyc(1);
        zr = 1'b0;
        for (int k = 0; k < 8; k++) push(k, 16'($urandom));
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("bp_d", {16'd0, bus1.o_z_d}, 32'hBEEF);
            chk("bp_s", {29'd0, bus1.o_z_s}, 32'd5);
        end
        zr = 1'b1;
        cyc(1);
        chk("bp_next", {29'd0, bus1.o_z_s}, 32'd6);

        // Random traffic and random downstream stalls.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 8; k++) begin
                if (src[k].size() < 4 && $urandom_range(0, 2) == 0)
                    push(k, 16'($urandom));
            end
            zr = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        drain();

        // Reset while a beat is held under backpressure.
        for (int k = 0; k < 8; k++) begin
            push(k, 16'($urandom));
            push(k, 16'($urandom));
        end
        cyc(1);
        zr = 1'b0;
        cyc(1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst_v", {31'd0, bus1.o_z_v}, 32'd0);
        zr = 1'b1;
        cyc(1);
        chk("rst_first", {29'd0, bus1.o_z_s}, 32'd0);
        drain();
        chk("conserve", 32'(pushed), 32'(delivered + dropped));
        chk("dropped", 32'(dropped), 32'd1);

        // Fixed priority instance: input 0 always wins over 4.
        bus0.i_a0_v = 1'b1;
        bus0.i_a0_d = 16'h0A00;
        bus0.i_a4_v = 1'b1;
        bus0.i_a4_d = 16'h0A04;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fp_r0", {31'd0, bus0.o_a0_r}, 32'd1);
            chk("fp_r4", {31'd0, bus0.o_a4_r}, 32'd0);
            @(posedge clk);
            #1;
            chk("fp_s0", {29'd0, bus0.o_z_s}, 32'd0);
        end
        bus0.i_a0_v = 1'b0;
        #1;
        chk("fp_r4b", {31'd0, bus0.o_a4_r}, 32'd1);
        @(posedge clk);
        #1;
        bus0.i_a4_v = 1'b0;
        chk("fp_s4", {29'd0, bus0.o_z_s}, 32'd4);
        chk("fp_d4", {16'd0, bus0.o_z_d}, 32'h0A04);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
